uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 5: uart_clk rising edges per serial bit.
REQ-002 SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: power of two; used only when UART_TX_FIFO_EN is defined.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 uart_clk  input  1  prescaler square wave at OVERSAMPLE x baud, synchronous to clk.
REQ-007 data  input  8  byte to transmit.
REQ-008 valid  input  1  data is offered this cycle.
REQ-009 ready  output  1  block accepts data this cycle.
REQ-010 tx  output  1  serial output, 8N1 (or 8N2), idle high, registered.
REQ-011 busy  output  1  a frame is in progress or a byte is queued.

Function
REQ-012 SHALL derive a one-clk tick on each rising edge of uart_clk, detected by registering uart_clk once and comparing; no other clock domain.
REQ-013 SHALL transfer a byte on any clk edge where valid && ready; data SHALL be ignored otherwise.
REQ-014 SHALL implement states IDLE, START, DATA, STOP; all state changes SHALL occur only on tick cycles.
REQ-015 IDLE -> START on the first tick after a byte is queued; tx SHALL go low on the clk after that tick.
REQ-016 Each bit SHALL last exactly OVERSAMPLE ticks, counted by a tick counter that reloads on every bit boundary.
REQ-017 DATA SHALL shift out 8 bits LSB first, using a 3-bit index that wraps 7 -> STOP.
REQ-018 STOP SHALL hold tx high for STOP_BITS x OVERSAMPLE ticks, then go to START if a byte is queued (no idle gap), else IDLE.
REQ-019 The transmitted byte SHALL be latched into a shift register at IDLE/STOP -> START; later writes SHALL NOT corrupt the frame in flight.
REQ-020 busy SHALL be high when state != IDLE or the queue is non-empty.
REQ-021 If uart_clk stops toggling, the state machine SHALL freeze with tx holding its current level; no timeout.
REQ-022 Accept and dequeue in the same cycle SHALL be allowed without loss or duplication.

Reset
REQ-023 On reset: state=IDLE, tx=1, busy=0, ready=1, queue empty, counters=0, edge register=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 on the clk following reset assertion; queued bytes SHALL be discarded.
REQ-025 A valid asserted during reset SHALL NOT be accepted.

Configuration
REQ-026 Macro UART_TX_FIFO_EN: when defined, the queue SHALL be a FIFO of FIFO_DEPTH bytes; ready=0 only when full; bytes SHALL be sent in order.
REQ-027 Without UART_TX_FIFO_EN, the queue SHALL be a single holding register; ready SHALL be high only when it is empty, and SHALL deassert on the cycle after acceptance.

Verification
REQ-028 12 MHz clk, 48 kHz uart_clk, send 0x55 -> tx reads 0,1,0,1,0,1,0,1,0,1, with each bit 1250 clk wide (+/-1); then idle high; busy falls after stop.
REQ-029 Send 0x00 then 0xFF back-to-back -> two frames with no idle gap between stop bit and next start bit; total 20 bit periods.
REQ-030 With UART_TX_FIFO_EN and FIFO_DEPTH=4, assert valid for 6 cycles during a frame -> ready drops after 4 accepts; 5 bytes go out in order (1 in flight + 4 queued).
REQ-031 Reset asserted 3 bit periods into a 0xA3 frame -> tx=1 on the next clk, busy=0, no further frame.
REQ-032 STOP_BITS=2, send 0x0F -> stop high for 10 ticks before the next start bit.
REQ-033 Hold uart_clk low mid-frame for 10000 clk -> tx constant; resumes the remaining bits correctly when toggling restarts.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake into uart_tx (master offers data/valid, slave returns ready).
interface uart_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8N1/8N2 serial transmitter paced by uart_clk rising edges; define UART_TX_FIFO_EN for a FIFO_DEPTH-byte queue instead of a holding register.
module uart_tx #(
  parameter int OVERSAMPLE = 5,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     uart_clk,
  uart_tx_if.slave bus,
  output logic     tx,
  output logic     busy
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  localparam int CW = $clog2(STOP_BITS * OVERSAMPLE + 1);
  localparam logic [CW-1:0] BIT_END  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS * OVERSAMPLE - 1);
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fifo_depth
    $error("uart_tx: FIFO_DEPTH must be a power of two");
  end
  state_t        state;
  logic          uart_clk_q;
  logic          tick;
  logic [CW-1:0] cnt;
  logic [2:0]    idx;
  logic [7:0]    shreg;
  logic          accept;
  logic          pop;
  logic          q_nonempty;
  logic [7:0]    q_head;
  assign tick   = uart_clk & ~uart_clk_q;
  assign accept = bus.valid & bus.ready;
  assign pop    = tick & q_nonempty & (state == IDLE | (state == STOP & cnt == STOP_END));
  assign busy   = (state != IDLE) | q_nonempty;
`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  assign bus.ready  = count != FULL;
  assign q_nonempty = count != '0;
  assign q_head     = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) mem[wr_ptr] <= bus.data;
      wr_ptr <= wr_ptr + {{(AW-1){1'b0}}, accept};
      rd_ptr <= rd_ptr + {{(AW-1){1'b0}}, pop};
      count  <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
    end
  end
`else
  logic       hold_full;
  logic [7:0] hold;
  assign bus.ready  = ~hold_full;
  assign q_nonempty = hold_full;
  assign q_head     = hold;
  // accept needs an empty register and pop a full one, so they never coincide
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_full <= 1'b0;
      hold      <= '0;
    end else begin
      hold_full <= accept | (hold_full & ~pop);
      hold      <= accept ? bus.data : hold;
    end
  end
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      uart_clk_q <= 1'b0;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      tx         <= 1'b1;
    end else begin
      uart_clk_q <= uart_clk;
      if (pop) begin
        state <= START;
        shreg <= q_head;
        tx    <= 1'b0;
        cnt   <= '0;
      end else if (tick) begin
        case (state)
          START: begin
            cnt   <= (cnt == BIT_END) ? '0 : cnt + 1'b1;
            state <= (cnt == BIT_END) ? DATA : START;
            tx    <= (cnt == BIT_END) ? shreg[0] : tx;
          end
          DATA: begin
            cnt <= (cnt == BIT_END) ? '0 : cnt + 1'b1;
            if (cnt == BIT_END) begin
              idx   <= idx + 3'd1;
              state <= (idx == 3'd7) ? STOP : DATA;
              tx    <= (idx == 3'd7) ? 1'b1 : shreg[idx + 3'd1];
            end
          end
          STOP: begin
            cnt   <= (cnt == STOP_END) ? '0 : cnt + 1'b1;
            state <= (cnt == STOP_END) ? IDLE : STOP;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, queueing, reset abort and stall behaviour.
module tb_uart_tx;
  localparam int BIT = 40;
`ifdef UART_TX_FIFO_EN
  localparam logic FIFO = 1'b1;
`else
  localparam logic FIFO = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_clk = 1'b0;
  logic       uart_run = 1'b1;
  logic [1:0] div = 2'd0;
  logic       tx, busy, tx2, busy2;
  int         checks = 0;
  int         errors = 0;
  uart_tx_if bus();
  uart_tx_if bus2();
  uart_tx #(.OVERSAMPLE(5), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .uart_clk(uart_clk), .bus(bus), .tx(tx), .busy(busy));
  uart_tx #(.OVERSAMPLE(5), .STOP_BITS(2), .FIFO_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .uart_clk(uart_clk), .bus(bus2), .tx(tx2), .busy(busy2));
  always #5 clk = ~clk;
  // uart_clk period is 8 clk, so one tick per 8 clk and one bit per 40 clk
  always @(posedge clk) begin
    if (uart_run) begin
      div <= div + 2'd1;
      if (div == 2'd3) uart_clk <= ~uart_clk;
    end
  end

  function automatic logic sig(input int what);
    case (what)
      0: return tx;
      1: return tx2;
      2: return busy;
      default: return busy2;
    endcase
  endfunction

  task automatic send(input bit two, input logic [7:0] d);
    if (two) begin bus2.data = d; bus2.valid = 1'b1; end
    else begin bus.data = d; bus.valid = 1'b1; end
    @(negedge clk);
    bus.valid = 1'b0;
    bus2.valid = 1'b0;
  endtask

  task automatic wait_fall(input int what, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      ok = (sig(what) === 1'b0);
    end
  endtask

  task automatic measure(input int what, input logic lvl, output int w);
    w = 1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (sig(what) !== lvl) break;
      w++;
    end
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
  endtask

  task automatic rx_byte(input int what, input int pre, input int stall_bit,
                         output logic [7:0] b, output logic stop, output int bad);
    int   w0;
    logic lvl;
    bad = 0;
    w0 = 0;
    repeat (BIT / 2 - pre) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (BIT - w0) @(negedge clk);
      w0 = 0;
      b[i] = sig(what);
      if (i == stall_bit) begin
        while (uart_clk !== 1'b0 && w0 < 16) begin @(negedge clk); w0++; end
        uart_run = 1'b0;
        lvl = sig(what);
        repeat (10000) begin
          @(negedge clk);
          if (sig(what) !== lvl || sig(what + 2) !== 1'b1) bad++;
        end
        uart_run = 1'b1;
      end
    end
    repeat (BIT - w0) @(negedge clk);
    stop = sig(what);
  endtask

  task automatic test_reset();
    int lows;
    reset = 1'b1;
    bus.data = 8'h77;
    bus.valid = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ready); end
    reset = 1'b0;
    bus.valid = 1'b0;
    count_lows(2 * BIT, lows);
    checks++; if (lows != 0) begin errors++; $display("FAIL reset_valid_ignored: got %0d low cycles want 0", lows); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_valid_busy: got %b want 0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] d;
    logic       lvl;
    int         w, lows;
    bit         ok;
    d = 8'h55;
    send(0, d);
    checks++; if (bus.ready !== FIFO) begin errors++; $display("FAIL basic_ready_after_accept: got %b want %b", bus.ready, FIFO); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_fall(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_start: got no start bit want start bit"); end
    for (int k = 0; k < 9; k++) begin
      lvl = (k == 0) ? 1'b0 : d[k - 1];
      checks++; if (tx !== lvl) begin errors++; $display("FAIL basic_bit%0d_level: got %b want %b", k, tx, lvl); end
      measure(0, lvl, w);
      checks++; if (w != BIT) begin errors++; $display("FAIL basic_bit%0d_width: got %0d want %0d", k, w, BIT); end
    end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL basic_stop_level: got %b want 1", tx); end
    measure(2, 1'b1, w);
    checks++; if (w != BIT) begin errors++; $display("FAIL basic_busy_fall: got %0d want %0d", w, BIT); end
    count_lows(2 * BIT, lows);
    checks++; if (lows != 0) begin errors++; $display("FAIL basic_idle_high: got %0d low cycles want 0", lows); end
  endtask

  task automatic test_back_to_back();
    int lo1, hi, lo2, tail;
    bit ok;
    send(0, 8'h00);
    wait_fall(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_start: got no start bit want start bit"); end
    send(0, 8'hFF);
    measure(0, 1'b0, lo1);
    lo1 = lo1 + 1;
    measure(0, 1'b1, hi);
    measure(0, 1'b0, lo2);
    measure(2, 1'b1, tail);
    checks++; if (lo1 != 9 * BIT) begin errors++; $display("FAIL b2b_first_low: got %0d want %0d", lo1, 9 * BIT); end
    checks++; if (hi != BIT) begin errors++; $display("FAIL b2b_stop_gap: got %0d want %0d", hi, BIT); end
    checks++; if (lo2 != BIT) begin errors++; $display("FAIL b2b_second_start: got %0d want %0d", lo2, BIT); end
    checks++; if (tail != 9 * BIT) begin errors++; $display("FAIL b2b_tail: got %0d want %0d", tail, 9 * BIT); end
    checks++; if (lo1 + hi + lo2 + tail != 20 * BIT) begin errors++; $display("FAIL b2b_total: got %0d want %0d", lo1 + hi + lo2 + tail, 20 * BIT); end
  endtask

`ifndef UART_TX_FIFO_EN
  task automatic test_hold();
    logic [7:0] b;
    logic       stop;
    int         bad, lows;
    bit         ok;
    send(0, 8'h3C);
    wait_fall(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_start: got no start bit want start bit"); end
    send(0, 8'h81);
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", bus.ready); end
    bus.data = 8'h99;
    bus.valid = 1'b1;
    repeat (3) @(negedge clk);
    bus.valid = 1'b0;
    rx_byte(0, 4, -1, b, stop, bad);
    checks++; if (b !== 8'h3C) begin errors++; $display("FAIL hold_frame1: got %h want 3c", b); end
    checks++; if (stop !== 1'b1) begin errors++; $display("FAIL hold_stop1: got %b want 1", stop); end
    wait_fall(0, ok);
    rx_byte(0, 0, -1, b, stop, bad);
    checks++; if (b !== 8'h81) begin errors++; $display("FAIL hold_frame2: got %h want 81", b); end
    count_lows(3 * BIT, lows);
    checks++; if (lows != 0) begin errors++; $display("FAIL hold_rejected_write: got %0d low cycles want 0", lows); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy_end: got %b want 0", busy); end
  endtask
`else
  task automatic test_fifo();
    logic [7:0] b;
    logic       stop;
    int         bad, acc;
    bit         ok;
    send(0, 8'h11);
    wait_fall(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fifo_start: got no start bit want start bit"); end
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bus.data = 8'h21 + 8'(i);
      bus.valid = 1'b1;
      if (bus.ready === 1'b1) acc++;
      @(negedge clk);
    end
    bus.valid = 1'b0;
    checks++; if (acc != 4) begin errors++; $display("FAIL fifo_accepts: got %0d want 4", acc); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready: got %b want 0", bus.ready); end
    rx_byte(0, 6, -1, b, stop, bad);
    checks++; if (b !== 8'h11) begin errors++; $display("FAIL fifo_frame0: got %h want 11", b); end
    for (int k = 0; k < 4; k++) begin
      wait_fall(0, ok);
      rx_byte(0, 0, -1, b, stop, bad);
      checks++; if (b !== 8'h21 + 8'(k)) begin errors++; $display("FAIL fifo_frame%0d: got %h want %h", k + 1, b, 8'h21 + 8'(k)); end
    end
    measure(2, 1'b1, bad);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fifo_busy_end: got %b want 0", busy); end
  endtask
`endif

  task automatic test_reset_mid();
    int lows, bhigh;
    bit ok;
    send(0, 8'hA3);
    wait_fall(0, ok);
    send(0, 8'h5A);
    repeat (3 * BIT - 1) @(negedge clk);
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL reset_mid_pre: got %b want 0", tx); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_mid_tx: got %b want 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b want 1", bus.ready); end
    reset = 1'b0;
    lows = 0;
    bhigh = 0;
    repeat (4 * BIT) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) bhigh++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL reset_mid_no_frame: got %0d low cycles want 0", lows); end
    checks++; if (bhigh != 0) begin errors++; $display("FAIL reset_mid_queue_dropped: got %0d busy cycles want 0", bhigh); end
  endtask

  task automatic test_stall();
    logic [7:0] b;
    logic       stop;
    int         bad, w;
    bit         ok;
    send(0, 8'hC5);
    wait_fall(0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_start: got no start bit want start bit"); end
    rx_byte(0, 0, 2, b, stop, bad);
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_frozen: got %0d changed cycles want 0", bad); end
    checks++; if (b !== 8'hC5) begin errors++; $display("FAIL stall_byte: got %h want c5", b); end
    checks++; if (stop !== 1'b1) begin errors++; $display("FAIL stall_stop: got %b want 1", stop); end
    measure(2, 1'b1, w);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_stop2();
    int s, h1, l1, stp, l2, tail;
    bit ok;
    send(1, 8'h0F);
    wait_fall(1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stop2_start: got no start bit want start bit"); end
    send(1, 8'hF0);
    measure(1, 1'b0, s);
    s = s + 1;
    measure(1, 1'b1, h1);
    measure(1, 1'b0, l1);
    measure(1, 1'b1, stp);
    measure(1, 1'b0, l2);
    measure(3, 1'b1, tail);
    checks++; if (s != BIT) begin errors++; $display("FAIL stop2_start_width: got %0d want %0d", s, BIT); end
    checks++; if (h1 != 4 * BIT) begin errors++; $display("FAIL stop2_ones: got %0d want %0d", h1, 4 * BIT); end
    checks++; if (l1 != 4 * BIT) begin errors++; $display("FAIL stop2_zeros: got %0d want %0d", l1, 4 * BIT); end
    checks++; if (stp != 2 * BIT) begin errors++; $display("FAIL stop2_stop_width: got %0d want %0d", stp, 2 * BIT); end
    checks++; if (l2 != 5 * BIT) begin errors++; $display("FAIL stop2_second_low: got %0d want %0d", l2, 5 * BIT); end
    checks++; if (tail != 6 * BIT) begin errors++; $display("FAIL stop2_tail: got %0d want %0d", tail, 6 * BIT); end
  endtask

  initial begin
    bus.data = 8'h00;
    bus.valid = 1'b0;
    bus2.data = 8'h00;
    bus2.valid = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
`ifndef UART_TX_FIFO_EN
    test_hold();
`else
    test_fifo();
`endif
    test_reset_mid();
    test_stall();
    test_stop2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
